// File: rtl/board_mem_pkg.sv
// Shared geometry, clear-FSM state encoding and row commands for the Tetris board store.
package tetris_pkg;

  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int XW   = 4;
  localparam int YW   = 5;
  localparam int CW   = 3;

  localparam logic [COLS-1:0] ROW_FULL = {COLS{1'b1}};

  typedef enum logic [1:0] {
    CLR_IDLE = 2'd0,
    CLR_SCAN = 2'd1,
    CLR_FILL = 2'd2,
    CLR_DONE = 2'd3
  } clr_state_t;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_COPY = 2'd1,
    CMD_ZERO = 2'd2,
    CMD_DONE = 2'd3
  } row_cmd_t;

  // Running line total sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [CW-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {14'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/board_mem_clear_fsm.sv
// Line-clear sequencer: walks read/write row pointers bottom-up and issues
// one row command per cycle to the storage array in board_mem.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// CLR_IDLE | waiting for clear_start; storage accepts game writes
// CLR_SCAN | row r full -> count it; otherwise copy row r into row w, w--
// CLR_FILL | zero row w, w--, until row 0 has been zeroed
// CLR_DONE | one cycle: publish count, pulse clear_done, return to idle
module board_clear_fsm
  import tetris_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clear_start,
  input  logic          i_row_full,
  output logic [YW-1:0] o_rd_row,
  output logic [YW-1:0] o_wr_row,
  output row_cmd_t      o_cmd,
  output logic [CW-1:0] o_cnt,
  output logic          o_busy,
  output logic          o_clear_done
);

  clr_state_t    r_state;
  logic [YW-1:0] r_rd;
  logic [YW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [CW-1:0] w_cnt_inc;

  // More than 4 full rows only arise from direct writes; clamp rather than wrap.
  assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + 3'd1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= CLR_IDLE;
      r_rd    <= '0;
      r_wr    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        CLR_IDLE: begin
          r_done <= 1'b0;
          if (i_clear_start) begin
            r_state <= CLR_SCAN;
            r_rd    <= YW'(ROWS-1);
            r_wr    <= YW'(ROWS-1);
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CLR_SCAN: begin
          if (i_row_full) r_cnt <= w_cnt_inc;
          else            r_wr  <= r_wr - YW'(1);
          r_rd <= r_rd - YW'(1);
          if (r_rd == '0) begin
            if (i_row_full || (r_cnt != '0)) begin
              r_state <= CLR_FILL;
            end else begin
              r_state <= CLR_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        CLR_FILL: begin
          r_wr <= r_wr - YW'(1);
          if (r_wr == '0) begin
            r_state <= CLR_DONE;
            r_done  <= 1'b1;
          end
        end
        CLR_DONE: begin
          r_state <= CLR_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= CLR_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    o_cmd = CMD_NONE;
    case (r_state)
      CLR_SCAN: o_cmd = i_row_full ? CMD_NONE : CMD_COPY;
      CLR_FILL: o_cmd = CMD_ZERO;
      CLR_DONE: o_cmd = CMD_DONE;
      default:  o_cmd = CMD_NONE;
    endcase
  end

  assign o_rd_row     = r_rd;
  assign o_wr_row     = r_wr;
  assign o_cnt        = r_cnt;
  assign o_busy       = r_busy;
  assign o_clear_done = r_done;

endmodule

// File: rtl/board_mem.sv
// Tetris playfield occupancy store with game read/write ports and line-clear engine.
// Optional registered display read port enabled by defining BOARD_VGA_PORT_EN.
module board_mem
  import tetris_pkg::*;
(
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic [XW-1:0] board_rx,
  input  logic [YW-1:0] board_ry,
  output logic          board_rdata,
  input  logic          board_we,
  input  logic [XW-1:0] board_wx,
  input  logic [YW-1:0] board_wy,
  input  logic          board_wdata,
  input  logic          clear_start,
  output logic          busy,
  output logic          clear_done,
  output logic [2:0]    lines_cleared,
  output logic [15:0]   lines_total,
  input  logic [XW-1:0] vga_rx,
  input  logic [YW-1:0] vga_ry,
  output logic          vga_rdata
);

  logic [COLS-1:0] r_rows [ROWS];
  logic [CW-1:0]   r_lines_cleared;
  logic [15:0]     r_lines_total;

  logic [YW-1:0]   w_rd_row;
  logic [YW-1:0]   w_wr_row;
  row_cmd_t        w_cmd;
  logic [CW-1:0]   w_cnt;
  logic            w_busy;
  logic            w_done;
  logic [COLS-1:0] w_scan_row;
  logic            w_row_full;
  logic            w_cell;
  logic            w_wr_ok;

  board_clear_fsm u_clear_fsm (
    .i_clk         (CLOCK_50),
    .i_reset       (reset),
    .i_clear_start (clear_start),
    .i_row_full    (w_row_full),
    .o_rd_row      (w_rd_row),
    .o_wr_row      (w_wr_row),
    .o_cmd         (w_cmd),
    .o_cnt         (w_cnt),
    .o_busy        (w_busy),
    .o_clear_done  (w_done)
  );

  always_comb begin
    w_scan_row = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (w_rd_row == YW'(i)) w_scan_row = r_rows[i];
    end
  end

  assign w_row_full = (w_scan_row == ROW_FULL);

  // Out-of-range reads return 1 so the playfield edges behave as walls.
  always_comb begin
    w_cell = 1'b1;
    if ((board_rx < XW'(COLS)) && (board_ry < YW'(ROWS))) begin
      w_cell = 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        if (board_ry == YW'(i)) w_cell = r_rows[i][board_rx];
      end
    end
  end

  assign board_rdata = w_cell;

  assign w_wr_ok = board_we && !w_busy &&
                   (board_wx < XW'(COLS)) && (board_wy < YW'(ROWS));

  // Copy target never sits above the source row, so in-place compaction is safe.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) r_rows[i] <= '0;
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        case (w_cmd)
          CMD_COPY: if (w_wr_row == YW'(i)) r_rows[i] <= w_scan_row;
          CMD_ZERO: if (w_wr_row == YW'(i)) r_rows[i] <= '0;
          CMD_NONE: if (w_wr_ok && (board_wy == YW'(i))) r_rows[i][board_wx] <= board_wdata;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_lines_cleared <= '0;
      r_lines_total   <= '0;
    end else if (w_cmd == CMD_DONE) begin
      r_lines_cleared <= w_cnt;
      r_lines_total   <= sat_add16(r_lines_total, w_cnt);
    end
  end

  assign busy          = w_busy;
  assign clear_done    = w_done;
  assign lines_cleared = r_lines_cleared;
  assign lines_total   = r_lines_total;

`ifdef BOARD_VGA_PORT_EN
  logic r_vga_rdata;
  logic w_vga_cell;

  always_comb begin
    w_vga_cell = 1'b0;
    if ((vga_rx < XW'(COLS)) && (vga_ry < YW'(ROWS))) begin
      for (int i = 0; i < ROWS; i++) begin
        if (vga_ry == YW'(i)) w_vga_cell = r_rows[i][vga_rx];
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_vga_rdata <= 1'b0;
    else       r_vga_rdata <= w_vga_cell;
  end

  assign vga_rdata = r_vga_rdata;
`else
  logic w_unused_vga;
  assign w_unused_vga = ^{vga_rx, vga_ry};
  assign vga_rdata    = 1'b0;
`endif

endmodule

// File: doc/board_mem.md
Name: board_mem

Overview:
- Occupancy store for the 10x20 Tetris playfield.
- Serves as the responder for the game FSM's board read and write ports, and contains the line-clear engine.
- Game logic writes locked piece cells, pulses clear_start, and waits for clear_done.
- Rows are held as ROWS x COLS flops. Row 0 is the top row; y increases downward.

Parameters:
COLS, 10, board width in cells
ROWS, 20, board height in cells
XW, 4, x address width
YW, 5, y address width

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous active-high reset
board_rx  in  XW  read x address
board_ry  in  YW  read y address
board_rdata  out  1  1 = cell occupied or address out of range
board_we  in  1  single-cycle write enable
board_wx  in  XW  write x address
board_wy  in  YW  write y address
board_wdata  in  1  value to store
clear_start  in  1  pulse: begin line-clear pass
busy  out  1  clear engine active
clear_done  out  1  one-cycle pulse at end of pass
lines_cleared  out  3  full rows removed by last pass (0..4)
lines_total  out  16  running total of cleared rows, saturating
vga_rx  in  XW  display read x (optional feature)
vga_ry  in  YW  display read y (optional feature)
vga_rdata  out  1  display read data (optional feature)

Behaviour:
- Reset, same cycle it is sampled:
  - all cells 0; FSM IDLE
  - busy=0, clear_done=0, lines_cleared=0, lines_total=0, vga_rdata=0
  - reset mid-pass aborts the pass; the board is cleared regardless of progress.
- Read port:
  - combinational, zero latency, reflects the current flop contents.
  - board_rx>=COLS or board_ry>=ROWS returns 1, acting as a wall for collision checks.
- Write port:
  - applied at the clock edge when board_we=1, in IDLE only.
  - writes with an out-of-range x or y are dropped.
  - writes while busy=1 are dropped.
- FSM states: IDLE, SCAN, FILL, DONE.
- IDLE:
  - clear_start=1 -> SCAN, with r=ROWS-1, w=ROWS-1, cnt=0.
  - a write in the same cycle as clear_start is applied first; the scan sees it.
- SCAN, one row per cycle:
  - row r full (all COLS bits 1): cnt++.
  - row r not full: copy row r -> row w, then w--.
  - r--; after processing r=0 -> FILL if cnt>0, else DONE.
  - in-place copy is safe because w>=r always holds.
- FILL, one row per cycle: zero row w, w--; after w=0 is zeroed -> DONE.
- DONE, one cycle:
  - clear_done=1; lines_cleared<=cnt.
  - lines_total<=lines_total+cnt, saturating at 16'hFFFF.
  - -> IDLE.
- busy=1 in SCAN, FILL and DONE.
- clear_start while busy is ignored, not queued.
- Pass length: ROWS + cnt + 1 cycles (21..25 at the defaults).
- board_rdata during a pass returns in-flight contents; the game FSM must not read until clear_done.
- lines_cleared holds its value until the next DONE or reset.
- cnt is 3 bits. The board can hold more than 4 full rows only through direct writes; the count is then clamped at 7, and lines_total adds the clamped value.

Optional Feature:
- Macro BOARD_VGA_PORT_EN.
- Defined:
  - second read port; vga_rdata <= cell(vga_rx, vga_ry), registered, 1-cycle latency.
  - out-of-range address returns 0.
  - independent of busy; shows in-flight contents.
- Undefined: vga_rdata tied 0; vga_rx and vga_ry unused.

Decomposition:
- Package tetris_pkg holds:
  - COLS, ROWS, XW, YW
  - clear-FSM state encoding
  - ROW_FULL constant ({COLS{1'b1}})
- Sub-module board_clear_fsm: owns the r/w pointers, cnt, and state. It emits a row-copy, row-zero or done command to the storage array.

Test Plan:
- Reset -> all 200 reads return 0; read (10,0) and (0,20) return 1; busy=0, lines_total=0.
- Write (3,19)=1; read (3,19) -> 1 the same cycle after the edge; write (12,5)=1 -> dropped, no cell changes.
- Fill row 19, put a cell at (0,18), pulse clear_start:
  - busy rises next cycle; clear_done after 22 cycles; lines_cleared=1.
  - (0,19)=1, row 18 all 0, lines_total=1.
- Fill rows 16..19 with (5,15)=1:
  - lines_cleared=4, (5,19)=1, rows 0..18 empty.
  - pass length 25 cycles; lines_total accumulates to 5.
- Board write and clear_start issued during busy -> both ignored, the board matches the model after done; assert reset mid-SCAN -> board all 0, busy=0 next cycle.
- With BOARD_VGA_PORT_EN: set (9,19); vga_rx=9, vga_ry=19 -> vga_rdata=1 one cycle later. Without the macro: vga_rdata stays 0.
